// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Bundles the serial stream, configuration and result signals of the
// parameterised sequence detector.
//
//   stream_in     serial data bit
//   in_valid      stream_in qualifier
//   cfg_load      load cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern   pattern, right-aligned, bit [len-1] received first
//   cfg_len       pattern length in bits
//   cfg_overlap   1 = overlapping matches, 0 = non-overlapping
//   clr_count     synchronous clear of match_count
//   pattern_found registered one-cycle match pulse
//   match_count   saturating match counter
//
// master: the side that drives the stream and configuration (testbench/host)
// slave : the detector
// -----------------------------------------------------------------------------
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
    logic                 stream_in;
    logic                 in_valid;
    logic                 cfg_load;
    logic [MAX_LEN-1:0]   cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_overlap;
    logic                 clr_count;
    logic                 pattern_found;
    logic [CNT_W-1:0]     match_count;

    modport master (
        output stream_in,
        output in_valid,
        output cfg_load,
        output cfg_pattern,
        output cfg_len,
        output cfg_overlap,
        output clr_count,
        input  pattern_found,
        input  match_count
    );

    modport slave (
        input  stream_in,
        input  in_valid,
        input  cfg_load,
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_overlap,
        input  clr_count,
        output pattern_found,
        output match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector with a run-time loadable pattern, length and
// overlap mode. Incoming bits are shifted into a history register (newest
// bit at the LSB); a fill counter tracks how many valid bits the history
// holds so a match is only declared once at least len bits have arrived.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   seq_detector_param_if.slave (stream, configuration, results)
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(5'b11010),
    parameter int                 DEFAULT_LEN = 5,
    parameter bit                 DEFAULT_OVL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Stored configuration
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               ovl_q,     ovl_d;

    // Datapath state
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               found_q,   found_d;
    logic [CNT_W-1:0]   count_q,   count_d;

    // Intermediate terms
    logic [MAX_LEN-1:0] cmp_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_sat;
    logic               sample;
    logic               match;

    // Only the low len bits take part in the comparison; anything stored
    // above the active length is masked off.
    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                cmp_mask[i] = 1'b1;
            end
        end
    end

    // Length clamp applied at load time so the compare path never sees a
    // length outside 1..MAX_LEN.
    always_comb begin
        if (bus.cfg_len <= LEN_MIN) begin
            cfg_len_sat = LEN_MIN;
        end else if (bus.cfg_len > FILL_MAX) begin
            cfg_len_sat = FILL_MAX;
        end else begin
            cfg_len_sat = bus.cfg_len;
        end
    end

    always_comb begin
        hist_shift = {history_q[MAX_LEN-2:0], bus.stream_in};
        fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

        // A configuration load discards the bit presented on the same edge.
        sample = bus.in_valid && !bus.cfg_load;

        // The match looks at the post-shift history and fill, so the pulse
        // for the last pattern bit appears one cycle after its sampling edge.
        match  = sample
              && (fill_inc >= len_q)
              && (((hist_shift ^ pattern_q) & cmp_mask) == '0);
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        history_d = history_q;
        fill_d    = fill_q;
        found_d   = 1'b0;
        count_d   = count_q;

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = cfg_len_sat;
            ovl_d     = bus.cfg_overlap;
            history_d = '0;
            fill_d    = '0;
        end else if (sample) begin
            history_d = hist_shift;
            // Non-overlap mode restarts the fill so the next match needs a
            // full fresh pattern; the history contents are then irrelevant.
            fill_d    = (match && !ovl_q) ? '0 : fill_inc;
            found_d   = match;
        end

        // Clear beats a simultaneous increment; the counter never wraps.
        if (bus.clr_count) begin
            count_d = '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEFAULT_PAT;
            len_q     <= LEN_W'(DEFAULT_LEN);
            ovl_q     <= DEFAULT_OVL;
            history_q <= '0;
            fill_q    <= '0;
            found_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            found_q   <= found_d;
            count_q   <= count_d;
        end
    end

    assign bus.pattern_found = found_q;
    assign bus.match_count   = count_q;

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN)+1: width of cfg_len.
REQ-004 Parameter DEFAULT_PAT, default 'b11010: pattern loaded at reset, right-aligned in MAX_LEN bits.
REQ-005 Parameter DEFAULT_LEN, default 5: pattern length loaded at reset.
REQ-006 Parameter DEFAULT_OVL, default 1: overlap mode loaded at reset.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 stream_in  input  1  serial data bit.
REQ-010 in_valid  input  1  stream_in is sampled only when high.
REQ-011 cfg_load  input  1  load cfg_pattern, cfg_len and cfg_overlap at this edge.
REQ-012 cfg_pattern  input  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
REQ-013 cfg_len  input  LEN_W  pattern length in bits.
REQ-014 cfg_overlap  input  1  1 = overlapping matches counted, 0 = non-overlapping.
REQ-015 clr_count  input  1  synchronous clear of match_count.
REQ-016 pattern_found  output  1  registered one-cycle match pulse.
REQ-017 match_count  output  CNT_W  saturating count of matches.

Function
REQ-018 The block SHALL keep a MAX_LEN-bit history shift register (newest bit at LSB) and a fill counter of range 0..MAX_LEN.
REQ-019 On an edge with in_valid=1 and cfg_load=0, the block SHALL shift stream_in into history and increment fill, saturating at MAX_LEN.
REQ-020 A match SHALL occur on that edge when updated fill >= len and the low len bits of updated history equal the low len bits of the stored pattern.
REQ-021 On a match, pattern_found SHALL be 1 during the cycle after that edge (latency 1 cycle from the sampling edge); otherwise pattern_found SHALL be 0.
REQ-022 Edges with in_valid=0 SHALL leave history and fill unchanged and drive pattern_found to 0.
REQ-023 In overlap mode, fill SHALL be kept after a match; in non-overlap mode, fill SHALL be cleared to 0 on the match edge.
REQ-024 On a match, match_count SHALL increment by 1, holding at 2^CNT_W-1 when already there (no wrap).
REQ-025 clr_count=1 SHALL set match_count to 0 at that edge and SHALL take priority over a simultaneous match increment.
REQ-026 cfg_load=1 SHALL store the new pattern, length and mode, clear history, fill and pattern_found, and discard any simultaneous in_valid bit.
REQ-027 cfg_load SHALL NOT change match_count.
REQ-028 cfg_len of 0 or 1 SHALL be stored as 1; cfg_len > MAX_LEN SHALL be stored as MAX_LEN.
REQ-029 Stored pattern bits above len SHALL be ignored in comparison.

Reset
REQ-030 rst=1 SHALL take priority over all other inputs.
REQ-031 rst=1 SHALL set history=0, fill=0, pattern_found=0, match_count=0, pattern=DEFAULT_PAT, len=DEFAULT_LEN, overlap=DEFAULT_OVL.
REQ-032 rst asserted mid-pattern SHALL discard partial progress; no pulse SHALL result from bits received before reset.

Verification
REQ-033 After reset, valid bits 1,1,0,1,0 -> pattern_found=1 exactly one cycle after the 5th sampling edge; match_count=1.
REQ-034 Load pattern 'b101, len=3, overlap=1; send 1,0,1,0,1 -> pulses after bits 3 and 5, match_count=2; with overlap=0 -> one pulse after bit 3 only, match_count=1.
REQ-035 Default pattern sent with in_valid low for 3 cycles between each bit -> single pulse after the last valid bit; no pulses in gap cycles.
REQ-036 CNT_W=2, six matches -> match_count 1,2,3,3,3,3; clr_count on the same edge as a match -> match_count=0.
REQ-037 Send 1,1,0,1, then cfg_load with the same pattern together with in_valid=1 and stream_in=0 -> no pulse; history restarts empty.
REQ-038 Send 1,1,0,1, assert rst for one edge, then send 0 -> no pulse; match_count=0.
